// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the round datapath.
// Coefficient words list the row-0 coefficients, most-significant byte first.
package aes_pkg;

    localparam logic [7:0]  AES_POLY  = 8'h1B;
    localparam logic [31:0] FWD_COEFS = 32'h02030101;
    localparam logic [31:0] INV_COEFS = 32'h0E0B0D09;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Constant multiply as an XOR of the xtime chain a, 2a, 4a, 8a, ...
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] m;
        p = '0;
        m = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in bits [31:24]).
module mix_col_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [31:0] coefs;
    logic [7:0]  a [4];

    always_comb begin
        coefs = inv ? INV_COEFS : FWD_COEFS;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r] = col_in[31 - 8*r -: 8];
        end
        col_out = '0;
        // Each row uses the same coefficient row rotated by the row index.
        for (int unsigned r = 0; r < 4; r++) begin
            col_out[31 - 8*r -: 8] = gf_mul(a[2'(r)],     coefs[31:24])
                                   ^ gf_mul(a[2'(r + 1)], coefs[23:16])
                                   ^ gf_mul(a[2'(r + 2)], coefs[15:8])
                                   ^ gf_mul(a[2'(r + 3)], coefs[7:0]);
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns stage: captures a 128-bit state, transforms one column per cycle,
// then holds the result until the downstream handshake completes.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    mc_state_t    state_q, state_d;
    logic [1:0]   col_q;
    logic         inv_q;
    logic [127:0] data_q;
    logic [31:0]  col_sel;
    logic [31:0]  col_new;

    always_comb begin
        col_sel = '0;
        unique case (col_q)
            2'd0: col_sel = data_q[127:96];
            2'd1: col_sel = data_q[95:64];
            2'd2: col_sel = data_q[63:32];
            2'd3: col_sel = data_q[31:0];
        endcase
    end

    mix_col_word u_mix_col_word (
        .col_in  (col_sel),
        .inv     (inv_q),
        .col_out (col_new)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            inv_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                data_q <= in_state;
                inv_q  <= in_inv;
                col_q  <= '0;
            end else if (state_q == CALC) begin
                unique case (col_q)
                    2'd0: data_q[127:96] <= col_new;
                    2'd1: data_q[95:64]  <= col_new;
                    2'd2: data_q[63:32]  <= col_new;
                    2'd3: data_q[31:0]   <= col_new;
                endcase
                col_q <= col_q + 2'd1;
            end
        end
    end

    assign out_state = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random scoreboard bench for mix_columns_seq.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q [$];

    mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: schoolbook polynomial product reduced modulo 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) a[row] = s[127 - 8*(4*c + row) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(a[(row + j) % 4], k[j]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
        int n;
        in_valid = 1'b1;
        in_state = s;
        in_inv   = inv;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 128'(in_ready), 128'(1'b1));
        if (in_ready) exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic receive(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid_timeout"}, 128'(out_valid), 128'(1'b1));
        if (out_valid && exp_q.size() > 0) chk(tag, out_state, exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] held;
        int got;
        int cyc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_state", out_state, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward FIPS-197 columns, with latency check
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("lat_E%0d", k), 128'(out_valid), 128'(1'b0));
        end
        @(negedge clk);
        chk("lat_E4", 128'(out_valid), 128'(1'b1));
        receive("fwd_columns");

        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        receive("fwd_full");

        // Inverse, with the in_inv pin toggled during CALC
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        for (int k = 0; k < 3; k++) begin
            in_inv = ~in_inv;
            @(negedge clk);
        end
        receive("inv_full_toggle");

        // Backpressure
        s = 128'h00112233445566778899aabbccddeeff;
        send(s, 1'b0, ref_mix(s, 1'b0));
        repeat (5) @(negedge clk);
        held = exp_q.size() > 0 ? exp_q[0] : '0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
            chk("bp_in_ready",  128'(in_ready),  128'(1'b0));
            chk("bp_out_state", out_state, held);
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid), 128'(1'b0));
        chk("bp_release_in_ready",  128'(in_ready),  128'(1'b1));

        // Input stall: second state held on in_valid during CALC
        s = 128'h0123456789abcdeffedcba9876543210;
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        in_valid = 1'b1;
        in_state = s;
        in_inv   = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
        receive("stall_first");
        send(s, 1'b1, ref_mix(s, 1'b1));
        receive("stall_second");

        // Asynchronous reset after column 1 is written
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("arst_out_state", out_state, '0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
        receive("after_reset_c6");

        // Random back-to-back traffic
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    s = {$urandom, $urandom, $urandom, $urandom};
                    send(s, i[0], ref_mix(s, i[0]));
                end
            end
            begin
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() > 0) chk($sformatf("rand_%0d", got), out_state, exp_q.pop_front());
                        else chk("rand_unexpected_output", 128'(out_valid), 128'(1'b0));
                        got++;
                    end
                end
                chk("rand_count", 128'(got), 128'(100));
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
        chk("rand_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
